net_tx_scheduler: RTL and testbench
===================================

# net_tx_scheduler

Round-robin scheduler that shares the single `network_stack_tx` instance among several payload sources on the `eth_refclk` domain, such as controller button changes, a debug burst and a heartbeat. Each source posts a 16-bit word with a one-cycle strobe. The block holds at most one pending word per source, grants sources in round-robin order, and emits each grant as a fixed-length framed burst on `axiov`/`axiod`. An enforced idle gap between bursts lets the transmit stack finish the previous frame.

## Interface
- `NUM_REQ`, 3: number of requesters (1..16).
- `DATA_SIZE`, 16: word width; fixed at 16 for the packet format.
- `PKT_WORDS`, 4: words per burst (≥4).
- `GAP_CYCLES`, 1024: minimum idle cycles after each burst (≥1).
- `clk` in 1: `eth_refclk`, 50 MHz.
- `rst` in 1: asynchronous reset, active-low (0 = reset).
- `req_valid` in NUM_REQ: per-source one-cycle post strobe.
- `req_data` in NUM_REQ*DATA_SIZE: source i occupies bits [i*16 +: 16].
- `req_drop` out NUM_REQ: one-cycle pulse when a pending word is overwritten.
- `axiov` out 1: burst word valid, to the stack's `axiiv`.
- `axiod` out 16: burst word, to the stack's `axiid`.
- `busy` out 1: high whenever state ≠ IDLE.
- `pkt_count` out 16: bursts started since reset; wraps.

## Operation
- **Per-source state.** Each source has a `pending` bit and a 16-bit `held` word.
- **Posting.** `req_valid[i]` sampled high sets `pending[i]` and loads `held[i]`.
  - If `pending[i]` was already set and is not being granted at the same edge, `req_drop[i]` pulses for one cycle. The newer word wins.
  - A post on the same edge that source i is granted leaves `pending[i]` = 1 with the new word and does not raise `req_drop`. The granted burst carries the old word.
- **Arbitration.**
  - Round-robin search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `last_grant` resets to NUM_REQ-1, so source 0 wins first.
  - Arbitration is evaluated only in IDLE.
- **FSM states:**
  - IDLE: when any bit is pending, grant, latch the word, clear the pending bit, drive word0, and go to SEND.
  - SEND: `axiov`=1 for PKT_WORDS consecutive cycles, with a word index of 0..PKT_WORDS-1. After the last word, load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: `axiov`=0; count down, then go to IDLE after exactly GAP_CYCLES cycles.
- **Burst format:**
  - word0 = {8'hC0, 4'h0, id[3:0]}.
  - word1 = `seq` (16-bit, starts at 0, increments per burst, wraps FFFF→0000).
  - word2 = payload.
  - words 3..PKT_WORDS-2 = 16'h0000.
  - word PKT_WORDS-1 = XOR of words 0..PKT_WORDS-2.
- **Counters.** `pkt_count` and `seq` increment on the IDLE→SEND edge.

## Timing
- **Reset values.** All outputs and all state are 0 while `rst`=0: `axiov`, `axiod`, `req_drop`, `busy`, `pkt_count`, `seq`, and `pending`. State is IDLE and `last_grant` = NUM_REQ-1.
- **Mid-burst reset.** Reset during SEND or GAP drops `axiov` asynchronously. The partial burst is abandoned and not resumed.
- **Latency.** A post in cycle 0 with the block IDLE produces `axiov` high in cycles 2..PKT_WORDS+1.
- **Spacing.** Between consecutive bursts there are exactly GAP_CYCLES+1 cycles with `axiov`=0: GAP_CYCLES in GAP plus 1 in IDLE.
- **No backpressure.** `axiov` is never deasserted inside a burst.
- **Register placement.**
  - `axiod` and `axiov` are registered.
  - `req_drop` is registered and asserted the cycle after the offending post.
  - `busy` is decoded from the state register.

## Structure
- **Package `net_tx_sched_pkg`:**
  - state enum {IDLE, SEND, GAP};
  - constant `HDR_TAG` = 8'hC0;
  - constant `MIN_PKT_WORDS` = 4;
  - a function that builds word k of the burst.
- **Sub-module `rr_arbiter`:**
  - combinational one-hot grant from the `pending` vector and `last_grant`;
  - parameterized by NUM_REQ;
  - also outputs the binary id.
- **Top of block:** pending/held registers, FSM, counters, and output registers.

## Test plan
All scenarios use NUM_REQ=3, PKT_WORDS=4, GAP_CYCLES=8.
- **Single post:** after reset, source 0 posts 16'h00F0 in cycle 0 -> `axiov` high in cycles 2–5 with words C000, 0000, 00F0, C0F0; `pkt_count`=1.
- **Simultaneous posts:** sources 0/1/2 post 1111/2222/3333 in the same cycle -> three bursts with ids 0, 1, 2 and seq 0, 1, 2; exactly 9 idle cycles between bursts; `req_drop` never asserted.
- **Overwrite:** source 1 posts AAAA, then BBBB, both during another source's SEND -> `req_drop[1]` pulses once, the cycle after the BBBB post; the later source-1 burst payload is BBBB; no AAAA burst is ever emitted.
- **Fairness:** source 0 posts every cycle; source 1 posts once -> grant order 0, 1, 0, 0…; source 1 is served within one burst period.
- **Reset mid-burst:** `rst` pulled low during word 2 -> `axiov` is 0 in the same cycle. After release, nothing is emitted until a new post, and that burst carries seq 0000.
- **Same-edge post:** source 2 posts on its own grant edge -> current burst carries the old word; a second burst follows with the new word; no `req_drop`.

Source files
------------

// File: rtl/net_tx_sched_pkg.sv
// Shared types and burst-format helpers for the transmit scheduler.
// Word layout: tag/id header, sequence number, payload, zero padding, XOR check word.
package net_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam logic [7:0] HDR_TAG       = 8'hC0;
  localparam int         MIN_PKT_WORDS = 4;

  // Word k of an n-word burst; the last word folds all earlier words together.
  function automatic logic [15:0] burst_word(input int k, input int n, input logic [3:0] id,
                                             input logic [15:0] seq, input logic [15:0] payload);
    logic [15:0] w0;
    w0 = {HDR_TAG, 4'h0, id};
    if (k == 0)          return w0;
    else if (k == 1)     return seq;
    else if (k == 2)     return payload;
    else if (k == n - 1) return w0 ^ seq ^ payload;
    else                 return 16'h0000;
  endfunction

endpackage

// File: rtl/net_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick among pending sources, starting after last_grant.
// Zero latency; no backpressure, the caller decides when a grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [3:0]         last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [3:0]         grant_id,
  output logic               grant_vld
);

  // Two passes: sources above last_grant first, then wrap to the bottom.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && pending[i] && (i > int'(last_grant))) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = 4'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && pending[i] && (i <= int'(last_grant))) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/net_tx_scheduler.sv
// Shares one transmit stack among NUM_REQ word sources; post-to-first-word latency is 2 cycles.
// No backpressure: bursts are never stalled, and a re-post over a pending word drops the older one.
module net_tx_scheduler
  import net_tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_SIZE  = 16,
  parameter int PKT_WORDS  = 4,
  parameter int GAP_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_drop,
  output logic                         axiov,
  output logic [15:0]                  axiod,
  output logic                         busy,
  output logic [15:0]                  pkt_count
);

  localparam int PKT_W = (PKT_WORDS < MIN_PKT_WORDS) ? MIN_PKT_WORDS : PKT_WORDS;
  localparam int IDX_W = $clog2(PKT_W + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t          state;
  logic [NUM_REQ-1:0] pending;
  logic [15:0]        held [NUM_REQ];
  logic [3:0]         last_grant;
  logic [IDX_W-1:0]   word_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        seq;
  logic [3:0]         cur_id;
  logic [15:0]        cur_seq;
  logic [15:0]        cur_payload;

  logic [NUM_REQ-1:0] grant_oh;
  logic [3:0]         grant_id;
  logic               grant_vld;
  logic               grant_now;
  logic [15:0]        grant_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld)
  );

  assign grant_now = (state == IDLE) && grant_vld;
  assign busy      = (state != IDLE);

  // Granted word selected by one-hot mux; reflects the value held before this edge.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_word = grant_word | held[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      req_drop <= '0;
      for (int i = 0; i < NUM_REQ; i++) held[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          pending[i]  <= 1'b1;
          held[i]     <= req_data[i*DATA_SIZE +: 16];
          req_drop[i] <= pending[i] && !(grant_now && grant_oh[i]);
        end else begin
          req_drop[i] <= 1'b0;
          if (grant_now && grant_oh[i]) pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 4'(NUM_REQ - 1);
      word_idx    <= '0;
      gap_cnt     <= '0;
      seq         <= '0;
      pkt_count   <= '0;
      cur_id      <= '0;
      cur_seq     <= '0;
      cur_payload <= '0;
      axiov       <= 1'b0;
      axiod       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur_id      <= grant_id;
            cur_seq     <= seq;
            cur_payload <= grant_word;
            last_grant  <= grant_id;
            seq         <= seq + 16'd1;
            pkt_count   <= pkt_count + 16'd1;
            axiov       <= 1'b1;
            axiod       <= burst_word(0, PKT_W, grant_id, seq, grant_word);
            word_idx    <= IDX_W'(1);
            state       <= SEND;
          end
        end
        SEND: begin
          if (word_idx == IDX_W'(PKT_W)) begin
            axiov   <= 1'b0;
            axiod   <= '0;
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= GAP;
          end else begin
            axiod    <= burst_word(32'(word_idx), PKT_W, cur_id, cur_seq, cur_payload);
            word_idx <= word_idx + IDX_W'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Directed and random posts checked every cycle against a burst-schedule reference model.
module tb_net_tx_scheduler;

  localparam int NR  = 3;
  localparam int PW  = 4;
  localparam int GAP = 8;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*16-1:0] req_data;
  logic [NR-1:0]    req_drop;
  logic             axiov;
  logic [15:0]      axiod;
  logic             busy;
  logic [15:0]      pkt_count;

  net_tx_scheduler #(
    .NUM_REQ    (NR),
    .DATA_SIZE  (16),
    .PKT_WORDS  (PW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_drop  (req_drop),
    .axiov     (axiov),
    .axiod     (axiod),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending words per source plus the scheduled window of the current burst.
  int          cyc = 0;
  logic [NR-1:0] pend;
  logic [15:0] hold [NR];
  int          last;
  logic [15:0] seq;
  logic [15:0] pkt;
  int          burst_lo;
  int          burst_hi;
  int          free_from;
  logic [15:0] ew [PW];
  logic [NR-1:0] drop;
  logic [15:0] cap [PW];
  logic [15:0] want1 [PW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = '0;
    for (int i = 0; i < NR; i++) hold[i] = '0;
    last = NR - 1;
    seq = '0;
    pkt = '0;
    burst_lo = -100;
    burst_hi = -100;
    free_from = 0;
    drop = '0;
  endtask

  task automatic model_edge();
    int g;
    logic [15:0] w0;
    g = -1;
    drop = '0;
    if (rst) begin
      if (cyc >= free_from && pend != '0) begin
        for (int off = 1; off <= NR; off++) begin
          int s;
          s = (last + off) % NR;
          if (g < 0 && pend[s]) g = s;
        end
        w0 = {8'hC0, 4'h0, 4'(g)};
        ew[0] = w0;
        ew[1] = seq;
        ew[2] = hold[g];
        ew[3] = w0 ^ seq ^ hold[g];
        burst_lo  = cyc + 1;
        burst_hi  = cyc + PW;
        free_from = cyc + PW + GAP + 1;
        seq++;
        pkt++;
        pend[g] = 1'b0;
        last = g;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i]) begin
          drop[i] = pend[i];
          pend[i] = 1'b1;
          hold[i] = req_data[i*16 +: 16];
        end
      end
    end
    cyc++;
  endtask

  task automatic compare();
    logic ev;
    ev = rst && (cyc >= burst_lo) && (cyc <= burst_hi);
    check("axiov", 32'(axiov), 32'(ev));
    if (ev) check("axiod", 32'(axiod), 32'(ew[cyc - burst_lo]));
    else if (!rst) check("axiod_rst", 32'(axiod), 32'h0);
    check("busy", 32'(busy), 32'(rst && (cyc >= burst_lo) && (cyc < free_from)));
    check("pkt_count", 32'(pkt_count), 32'(pkt));
    check("req_drop", 32'(req_drop), 32'(drop));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    req_valid = '0;
  endtask

  task automatic post(input int s, input logic [15:0] d);
    req_valid[s] = 1'b1;
    req_data[s*16 +: 16] = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && !(cyc >= free_from && pend == '0); k++) step();
    step();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    want1 = '{16'hC000, 16'h0000, 16'h00F0, 16'hC0F0};
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    step();

    // Single post from reset: fixed expected words.
    post(0, 16'h00F0);
    step();
    for (int k = 0; k < PW; k++) begin
      step();
      check("single_word", 32'(axiod), 32'(want1[k]));
    end
    check("single_pkt_count", 32'(pkt_count), 32'd1);
    drain();

    // Simultaneous posts from all sources.
    post(0, 16'h1111);
    post(1, 16'h2222);
    post(2, 16'h3333);
    step();
    drain();

    // Overwrite of source 1 during source 2's burst.
    post(2, 16'h7777);
    step();
    step();
    post(1, 16'hAAAA);
    step();
    post(1, 16'hBBBB);
    step();
    drain();

    // Fairness: source 0 floods, source 1 posts once.
    for (int k = 0; k < 45; k++) begin
      post(0, 16'(k));
      if (k == 3) post(1, 16'h0B0B);
      step();
    end
    drain();

    // Reset asserted during word 2.
    post(0, 16'h1234);
    step();
    for (int k = 0; k < 10 && cyc != burst_lo + 2; k++) step();
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_axiov", 32'(axiov), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_pkt", 32'(pkt_count), 32'h0);
    step();
    step();
    rst = 1'b1;
    repeat (20) step();
    post(2, 16'h5555);
    step();
    for (int k = 0; k < PW; k++) begin
      step();
      cap[k] = axiod;
    end
    check("midrst_seq0", 32'(cap[1]), 32'h0);
    check("midrst_payload", 32'(cap[2]), 32'h5555);
    drain();

    // Post on the grant edge of the same source.
    post(2, 16'h0A0A);
    step();
    post(2, 16'h0B0B);
    step();
    drain();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int s = 0; s < NR; s++) begin
        if ($urandom_range(0, 19) == 0) post(s, 16'($urandom));
      end
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
